switch_debounce: RTL



---
 rtl/switch_debounce.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: synchronises, debounces and edge-detects WIDTH switch inputs,
// and queues per-bit change events in a small FIFO with a valid/ready drain.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   sw_in         raw asynchronous switch levels
//   sw_state      debounced stable levels (registered)
//   sw_rise       one-cycle pulse per bit on accepted 0->1
//   sw_fall       one-cycle pulse per bit on accepted 1->0
//   evt_valid     event FIFO non-empty
//   evt_ready     consumer accepts head entry
//   evt_index     bit index of head event
//   evt_level     new level of head event
//   evt_overflow  sticky: an event was lost
module switch_debounce #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned IDX_W        = 4,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_index,
  output logic             evt_level,
  output logic             evt_overflow
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(STABLE_TICKS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned ENT_W  = IDX_W + 1;

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [WIDTH-1:0]  r_state;
  logic [WIDTH-1:0]  r_rise;
  logic [WIDTH-1:0]  r_fall;
  logic [WIDTH-1:0]  r_pend;
  logic              r_ovf;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_cnt [WIDTH];
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FCNT_W-1:0] r_count;

  logic              w_tick;
  logic [WIDTH-1:0]  w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0]  w_chg;
  logic              w_any;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_sel_lvl;
  logic [WIDTH-1:0]  w_sel_oh;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [WIDTH-1:0]  w_clr;
  logic [ENT_W-1:0]  w_head;

  // Two-flop synchroniser; nothing downstream looks at sw_in directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Per-bit debounce: accept a new level after STABLE_TICKS disagreeing ticks.
  always_comb begin
    w_state_nxt = r_state;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync2[i] == r_state[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
          w_state_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]   = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_chg = w_state_nxt ^ r_state;

  // Lowest-index pending bit wins the single push slot.
  always_comb begin
    w_any     = 1'b0;
    w_sel_idx = '0;
    w_sel_lvl = 1'b0;
    w_sel_oh  = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any       = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_lvl   = r_state[i];
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  assign w_full = (r_count == FCNT_W'(FIFO_DEPTH));
  assign w_push = w_any & ~w_full;
  assign w_clr  = w_push ? w_sel_oh : '0;
  assign w_pop  = evt_valid & evt_ready;

  // Debounced state, edge pulses, pending mask and sticky overflow.
  // A bit being pushed this cycle is not lost if it changes again at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rise  <= w_chg & w_state_nxt;
      r_fall  <= w_chg & r_state;
      r_pend  <= (r_pend & ~w_clr) | w_chg;
      if (|(r_pend & ~w_clr & w_chg)) r_ovf <= 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= {w_sel_idx, w_sel_lvl};
  end

  assign w_head       = r_mem[r_rptr];
  assign evt_valid    = (r_count != '0);
  assign evt_index    = evt_valid ? w_head[ENT_W-1:1] : '0;
  assign evt_level    = evt_valid & w_head[0];
  assign evt_overflow = r_ovf;
  assign sw_state     = r_state;
  assign sw_rise      = r_rise;
  assign sw_fall      = r_fall;

endmodule
